// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts, FSM states and
// the GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_t;

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KL_128:  return 4'(NR_128);
      KL_192:  return 4'(NR_192);
      default: return 4'(NR_256);
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Undo the S-box affine map, then invert in GF(2^8) as b^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b, p, r;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] result
);

  function automatic logic [127:0] shift_rows_inv(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [127:0] keyed;

  always_comb begin
    keyed  = add_round_key(inv_sub_bytes(shift_rows_inv(state)), round_key);
    result = last ? keyed : inv_mix(keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryptor: one inverse round per clock, round keys fetched
// from an external schedule store through rk_idx/rk.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int MAX_NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_key_len,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         err
);

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] round_out;
  logic [3:0]   round_q;
  logic [3:0]   nr_q;
  logic [3:0]   nr_in;

  assign nr_in    = nr_of(in_key_len);
  assign out_data = state_q;

  // DONE parks the index on the finished block's first key; it is never consumed.
  always_comb begin
    rk_idx = nr_q;
    case (fsm_q)
      ST_IDLE: rk_idx = nr_in;
      ST_RUN:  rk_idx = round_q;
      default: rk_idx = nr_q;
    endcase
  end

  aes_inv_round u_round (
    .state     (state_q),
    .round_key (rk),
    .last      (round_q == 4'd0),
    .result    (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      round_q   <= '0;
      nr_q      <= 4'(NR_128);
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (int'(nr_in) > MAX_NR) begin
              err <= 1'b1;
            end else begin
              state_q  <= in_data ^ rk;
              nr_q     <= nr_in;
              round_q  <= nr_in - 4'd1;
              in_ready <= 1'b0;
              fsm_q    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          state_q <= round_out;
          if (round_q == 4'd0) begin
            out_valid <= 1'b1;
            fsm_q     <= ST_DONE;
          end else begin
            round_q <= round_q - 4'd1;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench: forward-AES reference (encrypt + key expansion) feeding two decryptor
// instances (full and AES-128-only); decrypted output must recover plaintext.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_valid10;
  logic [127:0] in_data;
  logic [1:0]   in_key_len;
  logic         out_ready;

  logic         in_ready, out_valid, err;
  logic [3:0]   rk_idx;
  logic [127:0] rk, out_data;
  logic         in_ready10, out_valid10, err10;
  logic [3:0]   rk_idx10;
  logic [127:0] rk10, out_data10;

  logic [127:0] rk_mem [0:15];
  logic [7:0]   sbox_t [0:255];
  logic         sel;
  int           checks = 0;
  int           fails  = 0;

  always #5 clk = ~clk;

  assign rk   = rk_mem[rk_idx];
  assign rk10 = rk_mem[rk_idx10];

  logic         m_in_ready, m_out_valid;
  logic [3:0]   m_rk_idx;
  logic [127:0] m_out_data;
  assign m_in_ready  = sel ? in_ready10  : in_ready;
  assign m_out_valid = sel ? out_valid10 : out_valid;
  assign m_rk_idx    = sel ? rk_idx10    : rk_idx;
  assign m_out_data  = sel ? out_data10  : out_data;

  aes_inv_cipher_iter #(.MAX_NR(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key_len(in_key_len), .rk_idx(rk_idx), .rk(rk),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );

  aes_inv_cipher_iter #(.MAX_NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
    .in_data(in_data), .in_key_len(in_key_len), .rk_idx(rk_idx10), .rk(rk10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10), .err(err10)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic int exp_nr(input logic [1:0] kl);
    return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
  endfunction

  // S-box from its definition: brute-force multiplicative inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = exp_nr(kl);
    int nk = nr - 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[127-8*(4*c+q) -: 8] = s[127-8*(4*((c+q)%4)+q) -: 8];
      s = o;
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          o[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
        s = o;
      end
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered just after a negedge; returns just after the negedge following the out_ready handshake.
  task automatic run_block(input logic [127:0] ct, input logic [1:0] kl,
                           input logic [127:0] exp, input int stall, input string tag);
    int nr = exp_nr(kl);
    in_data = ct;
    in_key_len = kl;
    if (sel) in_valid10 = 1'b1; else in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready_idle"}, 128'(m_in_ready), 128'(1));
    chk({tag, "_rk_idx_idle"}, 128'(m_rk_idx), 128'(nr));
    @(negedge clk);
    in_valid = 1'b0;
    in_valid10 = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      in_key_len = 2'($urandom);
      in_data = rand128();
      #1;
      chk($sformatf("%s_rk_idx_%0d", tag, k), 128'(m_rk_idx), 128'(nr - k));
      chk($sformatf("%s_busy_%0d", tag, k), 128'({m_out_valid, m_in_ready}), 128'(0));
      @(negedge clk);
    end
    #1;
    chk({tag, "_latency"}, 128'({m_out_valid, m_in_ready}), 128'(2'b10));
    chk({tag, "_data"}, m_out_data, exp);
    for (int s = 0; s < stall; s++) begin
      if (sel) in_valid10 = 1'b1; else in_valid = 1'b1;
      @(negedge clk);
      #1;
      chk($sformatf("%s_stall_%0d", tag, s), 128'({m_out_valid, m_in_ready}), 128'(2'b10));
      chk($sformatf("%s_stall_data_%0d", tag, s), m_out_data, exp);
    end
    in_valid = 1'b0;
    in_valid10 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({tag, "_released"}, 128'({m_out_valid, m_in_ready}), 128'(2'b01));
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] key;
    logic [127:0] pt, ct;
    logic [1:0]   kl;
    rst = 1'b1;
    in_valid = 1'b0;
    in_valid10 = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_key_len = 2'b00;
    sel = 1'b0;
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_flags", 128'({in_ready, out_valid, err, in_ready10, out_valid10, err10}), 128'(6'b100100));
    chk("reset_data", out_data, 128'h0);
    chk("reset_rk_idx", 128'(rk_idx), 128'(10));

    // Known-answer vectors, model cross-checked against the published ciphertexts.
    expand(KEY, 2'b00);
    chk("model_c1", encrypt(PT, 10), C1);
    run_block(C1, 2'b00, PT, 5, "aes128_bp");
    expand(KEY, 2'b01);
    chk("model_c2", encrypt(PT, 12), C2);
    run_block(C2, 2'b01, PT, 0, "aes192");
    expand(KEY, 2'b10);
    chk("model_c3", encrypt(PT, 14), C3);
    run_block(C3, 2'b10, PT, 1, "aes256");
    run_block(C3, 2'b11, PT, 0, "aes256_kl11");

    // Randomized keys, lengths and plaintexts.
    for (int t = 0; t < 6; t++) begin
      key = {rand128(), rand128()};
      kl  = 2'($urandom_range(0, 3));
      pt  = rand128();
      expand(key, kl);
      ct = encrypt(pt, exp_nr(kl));
      run_block(ct, kl, pt, $urandom_range(0, 3), $sformatf("rand%0d", t));
    end

    // Capped instance rejects longer keys, then still decrypts AES-128.
    sel = 1'b1;
    for (int t = 0; t < 2; t++) begin
      in_data = rand128();
      in_key_len = (t == 0) ? 2'b01 : 2'b11;
      in_valid10 = 1'b1;
      @(negedge clk);
      in_valid10 = 1'b0;
      #1;
      chk($sformatf("reject%0d_err", t), 128'({err10, out_valid10, in_ready10}), 128'(3'b101));
      @(negedge clk);
      #1;
      chk($sformatf("reject%0d_err_end", t), 128'({err10, out_valid10, in_ready10}), 128'(3'b001));
    end
    expand(KEY, 2'b00);
    run_block(C1, 2'b00, PT, 0, "cap10_aes128");
    sel = 1'b0;

    // Reset in the middle of a block.
    in_data = C1;
    in_key_len = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_key_len = 2'b10;
    #1;
    chk("midrun_rst_flags", 128'({in_ready, out_valid, err}), 128'(3'b100));
    chk("midrun_rst_data", out_data, 128'h0);
    chk("midrun_rst_rk_idx", 128'(rk_idx), 128'(14));
    run_block(C1, 2'b00, PT, 2, "after_rst");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
